// File: rtl/cell_pkg.sv
// Shared constants, sequencer state encoding and the 640-wide cell address helper
// for the cell RAM arbiter.
package cell_pkg;

  localparam int unsigned H_CELLS = 640;
  localparam int unsigned V_CELLS = 480;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned ROW_W   = 9;
  localparam int unsigned COL_W   = 10;
  localparam int unsigned GEN_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // row*640 + col as two shifts and adds (640 = 512 + 128)
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    cell_addr = (ADDR_W'(row) << 9) + (ADDR_W'(row) << 7) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/cell_addr_calc.sv
// Combinational row*H_CELLS+col; shift-add for the native 640-wide grid,
// a plain multiply for any other width.
module cell_addr_calc #(
  parameter int unsigned H_CELLS = cell_pkg::H_CELLS,
  parameter int unsigned ADDR_W  = cell_pkg::ADDR_W
) (
  input  logic [cell_pkg::ROW_W-1:0] row_i,
  input  logic [cell_pkg::COL_W-1:0] col_i,
  output logic [ADDR_W-1:0]          addr_o
);
  import cell_pkg::*;

  generate
    if (H_CELLS == 640 && ADDR_W == cell_pkg::ADDR_W) begin : g_shift
      assign addr_o = cell_addr(row_i, col_i);
    end else begin : g_mul
      assign addr_o = ADDR_W'(row_i) * ADDR_W'(H_CELLS) + ADDR_W'(col_i);
    end
  endgenerate

endmodule

// File: rtl/cell_ram_arbiter.sv
// Single-port cell RAM arbiter: display reads win every cycle, the automaton
// engine is served only while a generation runs; one generation per frame.
module cell_ram_arbiter #(
  parameter int unsigned H_CELLS = cell_pkg::H_CELLS,
  parameter int unsigned V_CELLS = cell_pkg::V_CELLS,
  parameter int unsigned ADDR_W  = cell_pkg::ADDR_W
) (
  input  logic                       vga_clk,
  input  logic                       clr,
  input  logic                       disp_req,
  input  logic [cell_pkg::ROW_W-1:0] disp_row,
  input  logic [cell_pkg::COL_W-1:0] disp_col,
  output logic                       disp_cell,
  output logic                       disp_valid,
  input  logic                       vsync,
  input  logic                       step_en,
  output logic                       gen_start,
  input  logic                       gen_done,
  input  logic                       eng_req,
  input  logic                       eng_we,
  input  logic [ADDR_W-1:0]          eng_addr,
  input  logic                       eng_wdata,
  output logic                       eng_gnt,
  output logic                       eng_rvalid,
  output logic                       eng_rdata,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic                       ram_we,
  output logic                       ram_wdata,
  input  logic                       ram_rdata,
  output logic [cell_pkg::GEN_W-1:0] gen_count,
  output logic                       busy
);
  import cell_pkg::*;

  localparam int unsigned CELLS = H_CELLS * V_CELLS;

  state_e            state_q, state_d;
  logic              vsync_q;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic              disp_p1_q, disp_valid_q, disp_cell_q;
  logic              rd_p1_q, oor_p1_q, eng_rvalid_q, eng_rdata_q;
  logic [ADDR_W-1:0] disp_addr;
  logic              vsync_fall, in_range, run, gen_inc;

  cell_addr_calc #(
    .H_CELLS (H_CELLS),
    .ADDR_W  (ADDR_W)
  ) u_addr_calc (
    .row_i  (disp_row),
    .col_i  (disp_col),
    .addr_o (disp_addr)
  );

  assign vsync_fall  = vsync_q & ~vsync;
  assign in_range    = (32'(eng_addr) < CELLS);
  assign gen_count_d = gen_count_q + GEN_W'(gen_inc);

  // Sequencer state, frame-sync edge detector and generation counter
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      gen_count_q <= gen_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vsync_fall && step_en) state_d = ARM;
      ARM:     state_d = RUN;
      RUN:     if (gen_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gen_start = 1'b0;
    busy      = 1'b1;
    run       = 1'b0;
    gen_inc   = 1'b0;
    case (state_q)
      IDLE:    busy      = 1'b0;
      ARM:     gen_start = 1'b1;
      RUN:     run       = 1'b1;
      DONE:    gen_inc   = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  assign eng_gnt = eng_req & ~disp_req & run;

  // RAM port mux; out-of-range engine writes are granted but dropped
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    if (disp_req) begin
      ram_addr = disp_addr;
    end else if (eng_gnt) begin
      ram_addr  = eng_addr;
      ram_we    = eng_we & in_range;
      ram_wdata = eng_we & in_range & eng_wdata;
    end
  end

  // Two-stage read return: RAM latency plus an output register
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      disp_p1_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_cell_q  <= 1'b0;
      rd_p1_q      <= 1'b0;
      oor_p1_q     <= 1'b0;
      eng_rvalid_q <= 1'b0;
      eng_rdata_q  <= 1'b0;
    end else begin
      disp_p1_q    <= disp_req;
      disp_valid_q <= disp_p1_q;
      disp_cell_q  <= disp_p1_q & ram_rdata;
      rd_p1_q      <= eng_gnt & ~eng_we;
      oor_p1_q     <= ~in_range;
      eng_rvalid_q <= rd_p1_q;
      eng_rdata_q  <= rd_p1_q & ~oor_p1_q & ram_rdata;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_cell  = disp_cell_q;
  assign eng_rvalid = eng_rvalid_q;
  assign eng_rdata  = eng_rdata_q;
  assign gen_count  = gen_count_q;

endmodule

// File: tb/tb_cell_ram_arbiter.sv
// Bench for cell_ram_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based reference model.
module tb_cell_ram_arbiter;

  localparam int unsigned AW    = 19;
  localparam int unsigned NCELL = 640 * 480;
  localparam int unsigned MEMD  = 1 << AW;
  localparam int PH_IDLE = 0;
  localparam int PH_ARM  = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_DONE = 3;

  logic          vga_clk = 1'b0;
  logic          clr, disp_req, vsync, step_en, gen_done;
  logic [8:0]    disp_row;
  logic [9:0]    disp_col;
  logic          eng_req, eng_we, eng_wdata;
  logic [AW-1:0] eng_addr;
  logic          disp_cell, disp_valid, gen_start, eng_gnt, eng_rvalid, eng_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we, ram_wdata, ram_rdata;
  logic [15:0]   gen_count;
  logic          busy;

  cell_ram_arbiter dut (
    .vga_clk    (vga_clk),
    .clr        (clr),
    .disp_req   (disp_req),
    .disp_row   (disp_row),
    .disp_col   (disp_col),
    .disp_cell  (disp_cell),
    .disp_valid (disp_valid),
    .vsync      (vsync),
    .step_en    (step_en),
    .gen_start  (gen_start),
    .gen_done   (gen_done),
    .eng_req    (eng_req),
    .eng_we     (eng_we),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_gnt    (eng_gnt),
    .eng_rvalid (eng_rvalid),
    .eng_rdata  (eng_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .gen_count  (gen_count),
    .busy       (busy)
  );

  initial forever #5 vga_clk = ~vga_clk;

  typedef struct {
    int due;
    bit val;
  } rd_t;

  bit  mem     [MEMD];
  bit  ref_mem [MEMD];
  rd_t dq[$];
  rd_t eq[$];
  int  m_phase, m_count, cyc, checks, failures;
  bit  m_vprev, started, gnt_seen;

  // Deterministic initial RAM image; a few cells pinned to 1 for directed reads
  function automatic bit init_bit(input int unsigned i);
    int unsigned h;
    if (i == 100 || i == 642 || i == 307201) return 1'b1;
    h = i * 32'd2654435761;
    return h[16];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Cell RAM: one-cycle read latency
  initial begin
    ram_rdata = 1'b0;
    for (int i = 0; i < MEMD; i++) mem[i] = init_bit(i);
    forever begin
      @(posedge vga_clk);
      ram_rdata <= mem[ram_addr];
      if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
    end
  end

  // Reference model and per-cycle comparison
  initial begin : compare
    bit   exp_gnt, inr, dv, dc, ev, ed;
    int   daddr;
    m_phase = PH_IDLE; m_count = 0; m_vprev = 0; started = 0; cyc = 0; gnt_seen = 0;
    for (int i = 0; i < MEMD; i++) ref_mem[i] = init_bit(i);
    forever begin
      @(negedge vga_clk);
      inr     = (32'(eng_addr) < NCELL);
      exp_gnt = (eng_req === 1'b1) && (disp_req !== 1'b1) && (m_phase == PH_RUN);
      daddr   = int'(disp_row) * 640 + int'(disp_col);
      if (started) begin
        dv = 0; dc = 0; ev = 0; ed = 0;
        if (dq.size() > 0 && dq[0].due == cyc) begin dv = 1; dc = dq[0].val; void'(dq.pop_front()); end
        if (eq.size() > 0 && eq[0].due == cyc) begin ev = 1; ed = eq[0].val; void'(eq.pop_front()); end
        chk("disp_valid", 32'(disp_valid), 32'(dv));
        chk("disp_cell", 32'(disp_cell), 32'(dc));
        chk("eng_rvalid", 32'(eng_rvalid), 32'(ev));
        chk("eng_rdata", 32'(eng_rdata), 32'(ed));
        chk("eng_gnt", 32'(eng_gnt), 32'(exp_gnt));
        chk("ram_we", 32'(ram_we), 32'(exp_gnt && eng_we && inr));
        if (disp_req) chk("ram_addr_disp", 32'(ram_addr), daddr);
        else if (exp_gnt) chk("ram_addr_eng", 32'(ram_addr), 32'(eng_addr));
        if (exp_gnt && eng_we && inr) chk("ram_wdata", 32'(ram_wdata), 32'(eng_wdata));
        chk("gen_start", 32'(gen_start), 32'(m_phase == PH_ARM));
        chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        chk("gen_count", 32'(gen_count), m_count);
      end
      gnt_seen = eng_gnt && eng_req;
      if (started && exp_gnt && eng_we && inr) ref_mem[eng_addr] = eng_wdata;
      if (clr) begin
        m_phase = PH_IDLE; m_count = 0; m_vprev = 0;
        dq.delete(); eq.delete();
        started = 1;
      end else if (started) begin
        if (disp_req) dq.push_back('{due: cyc + 2, val: ref_mem[daddr]});
        if (exp_gnt && !eng_we) eq.push_back('{due: cyc + 2, val: inr ? ref_mem[eng_addr] : 1'b0});
        case (m_phase)
          PH_IDLE: if (m_vprev && !vsync && step_en) m_phase = PH_ARM;
          PH_ARM:  m_phase = PH_RUN;
          PH_RUN:  if (gen_done) m_phase = PH_DONE;
          default: begin m_phase = PH_IDLE; m_count = (m_count + 1) % 65536; end
        endcase
        m_vprev = vsync;
      end
      cyc++;
    end
  end

  // Frame-sync falling edge; returns in the first RUN cycle
  task automatic start_gen();
    step_en = 1; vsync = 1;
    tick;
    vsync = 0;
    tick;
    #2 chk("gen_start_pulse", 32'(gen_start), 32'd1);
    vsync = 1;
    tick;
    #2 chk("run_busy", 32'(busy), 32'd1);
    chk("gen_start_once", 32'(gen_start), 32'd0);
  endtask

  initial begin : stim
    int extra;
    int r;
    clr = 1; disp_req = 0; disp_row = '0; disp_col = '0; vsync = 1; step_en = 0;
    gen_done = 0; eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = 0;
    tick; tick;
    clr = 0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gen_count", 32'(gen_count), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_eng_rvalid", 32'(eng_rvalid), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_gen_start", 32'(gen_start), 32'd0);
    chk("rst_eng_gnt", 32'(eng_gnt), 32'd0);

    // Display read of row 1, column 2
    tick;
    disp_req = 1; disp_row = 9'd1; disp_col = 10'd2;
    #2 chk("disp_addr_642", 32'(ram_addr), 32'd642);
    tick;
    disp_req = 0;
    #2 chk("disp_valid_early", 32'(disp_valid), 32'd0);
    tick;
    #2 chk("disp_valid_n2", 32'(disp_valid), 32'd1);
    chk("disp_cell_n2", 32'(disp_cell), 32'd1);

    // Reset during RUN with an engine read in flight
    start_gen();
    eng_req = 1; eng_we = 0; eng_addr = 19'd5;
    #1 chk("midrst_gnt", 32'(eng_gnt), 32'd1);
    tick;
    eng_req = 0; clr = 1;
    tick;
    clr = 0;
    #2 chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gen_count", 32'(gen_count), 32'd0);
    chk("midrst_no_rvalid", 32'(eng_rvalid), 32'd0);
    tick;
    #2 chk("midrst_no_rvalid2", 32'(eng_rvalid), 32'd0);

    // Full generation; a second frame edge during RUN must not restart
    start_gen();
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) vsync = 0;
      if (i == 12) vsync = 1;
      #1 if (gen_start) extra++;
      tick;
    end
    chk("no_second_start", 32'(extra), 32'd0);
    gen_done = 1;
    tick;
    gen_done = 0;
    #2 chk("done_busy", 32'(busy), 32'd1);
    tick;
    #2 chk("gen_count_1", 32'(gen_count), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    tick; tick; tick;
    #2 chk("one_gen_per_frame", 32'(busy), 32'd0);

    // Display holds off an engine read for five cycles
    start_gen();
    disp_req = 1; disp_row = '0; disp_col = 10'd7;
    eng_req = 1; eng_we = 0; eng_addr = 19'd100;
    for (int i = 0; i < 5; i++) begin
      #1 chk("gnt_blocked", 32'(eng_gnt), 32'd0);
      tick;
    end
    disp_req = 0;
    #1 chk("gnt_after_disp", 32'(eng_gnt), 32'd1);
    tick;
    eng_req = 0;
    tick;
    #1 chk("contend_rvalid", 32'(eng_rvalid), 32'd1);
    chk("contend_rdata", 32'(eng_rdata), 32'd1);

    // Address boundary: last cell writes, first out-of-range cell is dropped
    eng_req = 1; eng_we = 1; eng_addr = 19'd307199; eng_wdata = 1;
    #1 chk("last_cell_we", 32'(ram_we), 32'd1);
    tick;
    eng_addr = 19'd307200;
    #1 chk("oor_gnt", 32'(eng_gnt), 32'd1);
    chk("oor_we", 32'(ram_we), 32'd0);
    tick;
    eng_we = 0; eng_addr = 19'd307201;
    #1 chk("oor_rd_gnt", 32'(eng_gnt), 32'd1);
    tick;
    eng_req = 0;
    tick;
    #1 chk("oor_rvalid", 32'(eng_rvalid), 32'd1);
    chk("oor_rdata", 32'(eng_rdata), 32'd0);
    gen_done = 1;
    tick;
    gen_done = 0;
    tick; tick;
    #1 chk("gen_count_2", 32'(gen_count), 32'd2);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      tick;
      disp_req = ($urandom % 100) < 35;
      disp_row = ($urandom % 8 == 0) ? 9'($urandom % 480) : 9'($urandom % 4);
      disp_col = 10'($urandom % 640);
      if (!eng_req || gnt_seen) begin
        eng_req = ($urandom % 3) != 0;
        eng_we  = $urandom % 2;
        r = $urandom % 16;
        if (r == 0)      eng_addr = 19'(307200 + $urandom % 64);
        else if (r == 1) eng_addr = 19'd307199;
        else             eng_addr = 19'($urandom % 2560);
        eng_wdata = $urandom % 2;
      end
      if ($urandom % 40 == 0) vsync = ~vsync;
      step_en  = ($urandom % 8) != 0;
      gen_done = ($urandom % 30) == 0;
    end
    eng_req = 0; disp_req = 0; gen_done = 0;
    tick; tick; tick; tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
